// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared command/state encodings and helpers for the mem_burst memory model
package mem_pkg;

    typedef enum logic [1:0] {
        CMD_NOP      = 2'd0,
        CMD_RESPONSE = 2'd1,
        CMD_READ     = 2'd2,
        CMD_WRITE    = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_DATA = 2'd1,
        WAIT    = 2'd2,
        RESP    = 2'd3
    } mem_state_e;

    // Number of bus beats that make up one line.
    function automatic int beats(input int bus_w, input int line_bytes);
        return (line_bytes * 8) / bus_w;
    endfunction

    // Seeded hash giving each storage word its pseudo-random power-up value.
    function automatic logic [31:0] init_hash(input logic [31:0] seed, input logic [31:0] idx);
        logic [31:0] x;
        x = seed ^ (idx * 32'h9E37_79B1);
        x = x ^ (x >> 16);
        x = x * 32'h85EB_CA6B;
        x = x ^ (x >> 13);
        return x;
    endfunction

endpackage

// File: rtl/mem_line_array.sv
// rtl/mem_line_array.sv - line storage with beat-indexed write/read ports and seeded power-up contents
module mem_line_array
    import mem_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int BUS_W  = 16,
    parameter int BEATS  = 8,
    parameter int BEAT_W = 3,
    parameter int SEED   = 225526
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BEAT_W-1:0] wr_beat,
    input  logic [BUS_W-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [BEAT_W-1:0] rd_beat,
    output logic [BUS_W-1:0]  rd_data
);

    localparam int WORDS = (2 ** ADDR_W) * BEATS;
    localparam int IDX_W = $clog2(WORDS);

    // Words are kept XORed with a seeded per-word mask, so a zero-filled array
    // reads back as pseudo-random contents while written data stays transparent.
    logic [BUS_W-1:0] mem [WORDS];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    function automatic logic [BUS_W-1:0] word_mask(input logic [IDX_W-1:0] idx);
        logic [31:0]      h;
        logic [BUS_W-1:0] m;
        h = init_hash(32'(SEED), 32'(idx));
        for (int i = 0; i < BUS_W; i++) begin
            m[i] = h[i[4:0]];
        end
        return m;
    endfunction

    assign wr_idx  = IDX_W'(wr_addr) * IDX_W'(BEATS) + IDX_W'(wr_beat);
    assign rd_idx  = IDX_W'(rd_addr) * IDX_W'(BEATS) + IDX_W'(rd_beat);
    assign rd_data = mem[rd_idx] ^ word_mask(rd_idx);

    // Commit one beat per enabled edge; storage is never cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data ^ word_mask(wr_idx);
        end
    end

endmodule

// File: rtl/mem_burst.sv
// rtl/mem_burst.sv - burst memory slave on shared cmd/data bus; MEM_BURST_STATS_EN adds rd_count/wr_count
module mem_burst
    import mem_pkg::*;
#(
    parameter int ADDR_W     = 15,
    parameter int BUS_W      = 16,
    parameter int LINE_BYTES = 16,
    parameter int LATENCY    = 100,
    parameter int SEED       = 225526
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr,
    inout  wire  [1:0]        cmd,
    inout  wire  [BUS_W-1:0]  data,
    output logic              busy
`ifdef MEM_BURST_STATS_EN
    ,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
`endif
);

    localparam int              BEATS     = beats(BUS_W, LINE_BYTES);
    localparam int              BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [9:0]      LAT_INIT  = 10'(LATENCY - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    mem_state_e        state, state_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [BEAT_W-1:0] beat_cnt, beat_nxt;
    logic [9:0]        lat_cnt, lat_nxt;
    logic              is_write, is_write_nxt;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [BEAT_W-1:0] wr_beat;
    logic [BUS_W-1:0]  rd_data;
    logic              cmd_is_read, cmd_is_write;
    logic              drive_resp, drive_data;

    assign cmd_is_read  = (cmd == CMD_READ);
    assign cmd_is_write = (cmd == CMD_WRITE);

    mem_line_array #(
        .ADDR_W (ADDR_W),
        .BUS_W  (BUS_W),
        .BEATS  (BEATS),
        .BEAT_W (BEAT_W),
        .SEED   (SEED)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en & reset_n),
        .wr_addr (wr_addr),
        .wr_beat (wr_beat),
        .wr_data (data),
        .rd_addr (addr_q),
        .rd_beat (beat_cnt),
        .rd_data (rd_data)
    );

    // State and counter registers; reset overrides any command on the same edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            addr_q   <= '0;
            beat_cnt <= '0;
            lat_cnt  <= '0;
            is_write <= 1'b0;
        end else begin
            state    <= state_nxt;
            addr_q   <= addr_nxt;
            beat_cnt <= beat_nxt;
            lat_cnt  <= lat_nxt;
            is_write <= is_write_nxt;
        end
    end

    // Next-state logic and write-port control for command, write-data, latency and response phases.
    always_comb begin
        state_nxt    = state;
        addr_nxt     = addr_q;
        beat_nxt     = beat_cnt;
        lat_nxt      = lat_cnt;
        is_write_nxt = is_write;
        wr_en        = 1'b0;
        wr_addr      = addr_q;
        wr_beat      = beat_cnt + BEAT_W'(1);
        case (state)
            IDLE: begin
                if (cmd_is_read) begin
                    addr_nxt     = addr;
                    beat_nxt     = '0;
                    lat_nxt      = LAT_INIT;
                    is_write_nxt = 1'b0;
                    state_nxt    = WAIT;
                end else if (cmd_is_write) begin
                    addr_nxt     = addr;
                    beat_nxt     = '0;
                    is_write_nxt = 1'b1;
                    wr_en        = 1'b1;
                    wr_addr      = addr;
                    wr_beat      = '0;
                    if (BEATS == 1) begin
                        lat_nxt   = LAT_INIT;
                        state_nxt = WAIT;
                    end else begin
                        state_nxt = WR_DATA;
                    end
                end
            end
            WR_DATA: begin
                wr_en    = 1'b1;
                beat_nxt = beat_cnt + BEAT_W'(1);
                if (beat_cnt + BEAT_W'(1) == LAST_BEAT) begin
                    beat_nxt  = '0;
                    lat_nxt   = LAT_INIT;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt == 10'd0) begin
                    beat_nxt  = '0;
                    state_nxt = RESP;
                end else begin
                    lat_nxt = lat_cnt - 10'd1;
                end
            end
            RESP: begin
                if (is_write || beat_cnt == LAST_BEAT) begin
                    beat_nxt  = '0;
                    state_nxt = IDLE;
                end else begin
                    beat_nxt = beat_cnt + BEAT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy       = (state != IDLE);
    assign drive_resp = (state == RESP);
    assign drive_data = (state == RESP) && !is_write;
    assign cmd        = drive_resp ? CMD_RESPONSE : 2'bzz;
    assign data       = drive_data ? rd_data : {BUS_W{1'bz}};

`ifdef MEM_BURST_STATS_EN
    // Saturating counts of accepted read and write commands.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (state == IDLE) begin
            if (cmd_is_read && rd_count != '1) begin
                rd_count <= rd_count + 32'd1;
            end
            if (cmd_is_write && wr_count != '1) begin
                wr_count <= wr_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_burst.sv
// tb/tb_mem_burst.sv - directed self-checking bench for mem_burst (stats checks under MEM_BURST_STATS_EN)
module tb_mem_burst;
    import mem_pkg::*;

    localparam int ADDR_W     = 15;
    localparam int BUS_W      = 16;
    localparam int LINE_BYTES = 16;
    localparam int LATENCY    = 4;
    localparam int BEATS      = 8;

    typedef logic [BUS_W-1:0] line_t [BEATS];

    logic              clk        = 1'b0;
    logic              reset_n    = 1'b0;
    logic [ADDR_W-1:0] addr       = '0;
    logic              tb_cmd_en  = 1'b0;
    logic [1:0]        tb_cmd     = 2'd0;
    logic              tb_data_en = 1'b0;
    logic [BUS_W-1:0]  tb_data    = '0;
    wire  [1:0]        cmd;
    wire  [BUS_W-1:0]  data;
    logic              busy;
`ifdef MEM_BURST_STATS_EN
    logic [31:0]       rd_count;
    logic [31:0]       wr_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    assign cmd  = tb_cmd_en  ? tb_cmd  : 2'bzz;
    assign data = tb_data_en ? tb_data : {BUS_W{1'bz}};

    always #5 clk = ~clk;

    mem_burst #(
        .ADDR_W     (ADDR_W),
        .BUS_W      (BUS_W),
        .LINE_BYTES (LINE_BYTES),
        .LATENCY    (LATENCY)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .addr    (addr),
        .cmd     (cmd),
        .data    (data),
        .busy    (busy)
`ifdef MEM_BURST_STATS_EN
        ,
        .rd_count (rd_count),
        .wr_count (wr_count)
`endif
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] resp_seen();
        return (cmd === 2'b01) ? 32'd1 : 32'd0;
    endfunction

    // Called at a negedge; command accepted at the next posedge T. Ends at the
    // negedge just before the release edge T+BEATS+LATENCY+1.
    task automatic write_line(input logic [ADDR_W-1:0] a, input line_t w, input bit chk);
        addr       = a;
        tb_cmd     = CMD_WRITE;
        tb_cmd_en  = 1'b1;
        tb_data_en = 1'b1;
        tb_data    = w[0];
        @(posedge clk);
        @(negedge clk);
        tb_cmd_en = 1'b0;
        for (int i = 1; i < BEATS; i++) begin
            tb_data = w[i];
            @(posedge clk);
            @(negedge clk);
        end
        tb_data_en = 1'b0;
        for (int n = BEATS; n <= BEATS + LATENCY + 1; n++) begin
            if (chk) begin
                if (n == BEATS + LATENCY - 1) check("wr_no_early_resp", resp_seen(), 32'd0);
                if (n == BEATS + LATENCY)     check("wr_resp", resp_seen(), 32'd1);
                if (n == BEATS + LATENCY + 1) begin
                    check("wr_released", resp_seen(), 32'd0);
                    check("wr_busy_low", 32'(busy), 32'd0);
                end
            end
            if (n < BEATS + LATENCY + 1) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
    endtask

    // Called at a negedge; read accepted at the next posedge T; beats sampled at
    // T+LATENCY+1..T+LATENCY+BEATS. Optional stray WRITE driven for edge T+2.
    task automatic read_line(input logic [ADDR_W-1:0] a, input line_t e, input bit chk, input bit inject);
        addr      = a;
        tb_cmd    = CMD_READ;
        tb_cmd_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tb_cmd_en = 1'b0;
        for (int n = 1; n <= BEATS + LATENCY + 1; n++) begin
            if (inject && n == 2) begin
                addr       = a;
                tb_cmd     = CMD_WRITE;
                tb_cmd_en  = 1'b1;
                tb_data    = 16'hDEAD;
                tb_data_en = 1'b1;
            end
            if (inject && n == 3) begin
                tb_cmd_en  = 1'b0;
                tb_data_en = 1'b0;
            end
            if (chk) begin
                if (n == LATENCY) begin
                    check("rd_no_early_resp", resp_seen(), 32'd0);
                    check("rd_busy_wait", 32'(busy), 32'd1);
                end else if (n > LATENCY && n <= LATENCY + BEATS) begin
                    check("rd_resp", resp_seen(), 32'd1);
                    check("rd_beat", 32'(data), 32'(e[n-LATENCY-1]));
                    if (n == LATENCY + BEATS) check("rd_busy_last", 32'(busy), 32'd1);
                end else if (n == LATENCY + BEATS + 1) begin
                    check("rd_released", resp_seen(), 32'd0);
                    check("rd_busy_low", 32'(busy), 32'd0);
                end
            end
            if (n < BEATS + LATENCY + 1) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        line_t l5, lmax, l1, old9, new9, mix9;
        logic  any_resp, any_busy;

        l5   = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888};
        lmax = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008};
        l1   = '{16'hA0A0, 16'hA1A1, 16'hA2A2, 16'hA3A3, 16'hA4A4, 16'hA5A5, 16'hA6A6, 16'hA7A7};
        old9 = '{16'h9000, 16'h9001, 16'h9002, 16'h9003, 16'h9004, 16'h9005, 16'h9006, 16'h9007};
        new9 = '{16'hC000, 16'hC001, 16'hC002, 16'hC003, 16'hC004, 16'hC005, 16'hC006, 16'hC007};
        mix9 = '{16'hC000, 16'hC001, 16'hC002, 16'hC003, 16'h9004, 16'h9005, 16'h9006, 16'h9007};

        // Reset held for two edges while a READ is presented.
        reset_n   = 1'b0;
        addr      = 5;
        tb_cmd    = CMD_READ;
        tb_cmd_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_resp", resp_seen(), 32'd0);
        reset_n   = 1'b1;
        tb_cmd_en = 1'b0;
        any_resp  = 1'b0;
        any_busy  = 1'b0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            any_resp |= (cmd === 2'b01);
            any_busy |= busy;
        end
        check("rst_never_resp", 32'(any_resp), 32'd0);
        check("rst_never_busy", 32'(any_busy), 32'd0);

        // Write then back-to-back read of line 5.
        write_line(5, l5, 1'b1);
        read_line(5, l5, 1'b1, 1'b0);

        // Top line address.
        write_line(15'h7FFF, lmax, 1'b1);
        read_line(15'h7FFF, lmax, 1'b1, 1'b0);

        // Commands during busy are ignored and do not touch storage.
        write_line(1, l1, 1'b0);
        read_line(1, l1, 1'b1, 1'b1);
        read_line(1, l1, 1'b1, 1'b0);

        // Reset after write beat 3 keeps beats 0-3, no response follows.
        write_line(9, old9, 1'b0);
        addr       = 9;
        tb_cmd     = CMD_WRITE;
        tb_cmd_en  = 1'b1;
        tb_data_en = 1'b1;
        tb_data    = new9[0];
        @(posedge clk);
        @(negedge clk);
        tb_cmd_en = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tb_data = new9[i];
            @(posedge clk);
            @(negedge clk);
        end
        tb_data = new9[4];
        reset_n = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset_n    = 1'b1;
        tb_data_en = 1'b0;
        any_resp   = 1'b0;
        any_busy   = 1'b0;
        repeat (15) begin
            @(posedge clk);
            @(negedge clk);
            any_resp |= (cmd === 2'b01);
            any_busy |= busy;
        end
        check("midrst_no_resp", 32'(any_resp), 32'd0);
        check("midrst_not_busy", 32'(any_busy), 32'd0);
        read_line(9, mix9, 1'b1, 1'b0);

`ifdef MEM_BURST_STATS_EN
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check("stats_rst_rd", rd_count, 32'd0);
        check("stats_rst_wr", wr_count, 32'd0);
        read_line(5, l5, 1'b0, 1'b0);
        write_line(20, l1, 1'b0);
        read_line(20, l1, 1'b0, 1'b0);
        write_line(21, l5, 1'b0);
        read_line(21, l5, 1'b0, 1'b0);
        check("stats_rd", rd_count, 32'd3);
        check("stats_wr", wr_count, 32'd2);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check("stats_clr_rd", rd_count, 32'd0);
        check("stats_clr_wr", wr_count, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_burst.md
# mem_burst

Parametrised main-memory model for the cache/memory bus: stores DEPTH lines of LINE_BYTES bytes and serves whole-line READ and WRITE bursts over a shared bidirectional command/data bus. It has a programmable access latency, write acknowledgement and a busy indication, and supports generic bus widths. It sits behind the cache controller as the sole slave on the memory-side bus.

## Interface
- ADDR_W, 15, line-address width; DEPTH = 2**ADDR_W lines
- BUS_W, 16, data bus width in bits; must divide LINE_BYTES*8
- LINE_BYTES, 16, bytes per line; BEATS = LINE_BYTES*8/BUS_W
- LATENCY, 100, access latency in cycles; legal range 1..1023
- SEED, 225526, seed for power-up pseudo-random contents
- clk  input  1  clock; all activity is on the rising edge
- reset_n  input  1  synchronous, active-low reset
- addr  input  ADDR_W  line address, sampled with READ/WRITE
- cmd  inout  2  command bus: NOP=0, RESPONSE=1, READ=2, WRITE=3; block drives it only in response phase
- data  inout  BUS_W  data bus; block drives it only in read-response phase
- busy  output  1  high from accepted command until bus release

## Operation
- FSM states: IDLE, WR_DATA, WAIT, RESP.
- IDLE: cmd=READ or WRITE sampled -> latch addr, beat_cnt=0, busy=1.
  - READ: -> WAIT with lat_cnt=LATENCY-1.
  - WRITE: beat 0 of data captured same edge -> WR_DATA (BEATS=1: straight to WAIT).
  - NOP, RESPONSE, X/Z: stay IDLE.
- WR_DATA: one beat captured per edge into line slice [BUS_W*beat +: BUS_W], beat 0 least significant; after beat BEATS-1 -> WAIT.
- WAIT: count lat_cnt down to 0 -> RESP.
- RESP, read: drive cmd=RESPONSE, data=beat beat_cnt for BEATS cycles, then release.
- RESP, write: drive cmd=RESPONSE one cycle, data stays z, then release.
- Release: cmd and data to z and busy=0 on the edge after the last response cycle -> IDLE. New commands are accepted from the next edge.
- While busy, cmd is not sampled. Master-driven commands during busy are ignored; master must drive NOP/z from the cycle after its command.
- Write beats commit per edge. Reset mid-write leaves already-captured beats in storage.
- Storage: filled with $random(SEED) at time 0; not cleared by reset.

## Timing
- Reset (reset_n=0 at edge): state=IDLE, busy=0, cmd=z, data=z, counters=0. Wins over any command on the same edge.
- Read accepted at edge T: response beats at T+LATENCY+1 .. T+LATENCY+BEATS; release at T+LATENCY+BEATS+1.
- Write accepted at edge T (beat 0): beats at T..T+BEATS-1; RESPONSE at T+BEATS+LATENCY-1+1 = T+BEATS+LATENCY; release the edge after.
- LATENCY>=1 guarantees one turnaround cycle between master release and memory drive.
- Back-to-back: a command sampled on the release edge is accepted.

## Configuration
- MEM_BURST_STATS_EN defined: adds outputs rd_count and wr_count (32-bit each, saturating). Each increments on its command-acceptance edge; both cleared by reset.
- MEM_BURST_STATS_EN undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Package mem_pkg:
  - cmd_e enum: 2-bit command encoding.
  - mem_state_e enum: FSM states.
  - Function beats(bus_w, line_bytes).
- Sub-module mem_line_array: DEPTH x LINE_BYTES*8 storage with beat-indexed read/write port and seeded init.
- Top: FSM, counters and tri-state drivers.

## Test plan
- Reset: reset_n=0 for 2 cycles with cmd=READ -> busy=0, cmd/data=z, no response ever.
- Read (BUS_W=16, LINE_BYTES=16, LATENCY=4): READ addr=5 at T -> RESPONSE and 8 beats at T+5..T+12 matching line 5 LSB-first; z at T+13.
- Write-then-read: WRITE addr=0x7FFF, beats 0x0001..0x0008 -> single RESPONSE at T+12; a later read returns 0x0001..0x0008.
- Busy ignore: READ addr=1 at T, WRITE at T+2 -> only line 1 read; storage unchanged; busy high until T+13.
- Mid-op reset: reset_n=0 after write beat 3 -> next read returns new beats 0-3 and old beats 4-7; no RESPONSE.
- Config with MEM_BURST_STATS_EN: 3 reads and 2 writes -> rd_count=3, wr_count=2; reset -> both 0.
